// File: rtl/bcd_pkg.sv
// Shared definitions for the signed BCD datapath: digit width, the BCD range limit,
// comparator FSM states and the three-way magnitude result.
package bcd_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      LT,
      EQ,
      GT
   } cmp_result_t;

   function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
      return d > BCD_MAX;
   endfunction

   // A one-digit operand still needs a one-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/signed_bcd_compare_seq_if.sv
// Request/result bundle of the digit-serial signed BCD comparator.
interface signed_bcd_compare_seq_if #(
   parameter int DIGITS = 3
);
   import bcd_pkg::*;

   logic                        start;
   logic                        sign_a;
   logic [DIGIT_W*DIGITS-1:0]   A;
   logic                        sign_b;
   logic [DIGIT_W*DIGITS-1:0]   B;
   logic                        busy;
   logic                        done;
   logic                        less;
   logic                        equal;
   logic                        greater;
   logic                        invalid;

   modport master (
      output start, sign_a, A, sign_b, B,
      input  busy, done, less, equal, greater, invalid
   );

   modport slave (
      input  start, sign_a, A, sign_b, B,
      output busy, done, less, equal, greater, invalid
   );

endinterface

// File: rtl/bcd_digit_cmp.sv
// Combinational comparator for one BCD digit pair.
module bcd_digit_cmp
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] a_i,
   input  logic [DIGIT_W-1:0] b_i,
   output logic               lt_o,
   output logic               eq_o,
   output logic               gt_o
);

   assign lt_o = (a_i <  b_i);
   assign eq_o = (a_i == b_i);
   assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/signed_bcd_compare_seq.sv
// Digit-serial signed BCD comparator: scans MSD first, stops at the first unequal
// digit, then resolves sign and magnitude into registered less/equal/greater flags.
module signed_bcd_compare_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   signed_bcd_compare_seq_if.slave  bus
);

   localparam int W     = DIGIT_W * DIGITS;
   localparam int IDX_W = idx_width(DIGITS);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d;
   logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   cmp_result_t        mag_q, mag_d;
   logic               a_nz_q, a_nz_d, b_nz_q, b_nz_d;
   logic               bad_q, bad_d;
   logic               done_q, done_d;
   logic               less_q, less_d;
   logic               equal_q, equal_d;
   logic               greater_q, greater_d;
   logic               invalid_q, invalid_d;

   logic [DIGIT_W-1:0] a_dig, b_dig;
   logic               dig_lt, dig_eq, dig_gt;
   cmp_result_t        dig_res;
   logic               bad_in;

   assign a_dig = a_q[int'(idx_q) * DIGIT_W +: DIGIT_W];
   assign b_dig = b_q[int'(idx_q) * DIGIT_W +: DIGIT_W];

   bcd_digit_cmp u_digit_cmp (
      .a_i  (a_dig),
      .b_i  (b_dig),
      .lt_o (dig_lt),
      .eq_o (dig_eq),
      .gt_o (dig_gt)
   );

   always_comb begin
      dig_res = EQ;
      if (dig_lt)
         dig_res = LT;
      else if (dig_gt)
         dig_res = GT;
   end

   // Range check runs on the live inputs so it is ready on the acceptance edge.
   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_bad(bus.A[i*DIGIT_W +: DIGIT_W]) || digit_bad(bus.B[i*DIGIT_W +: DIGIT_W]))
            bad_in = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      idx_d     = idx_q;
      mag_d     = mag_q;
      a_nz_d    = a_nz_q;
      b_nz_d    = b_nz_q;
      bad_d     = bad_q;
      done_d    = 1'b0;
      less_d    = less_q;
      equal_d   = equal_q;
      greater_d = greater_q;
      invalid_d = invalid_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d       = bus.A;
               b_d       = bus.B;
               sign_a_d  = bus.sign_a;
               sign_b_d  = bus.sign_b;
               idx_d     = IDX_TOP;
               mag_d     = EQ;
               a_nz_d    = 1'b0;
               b_nz_d    = 1'b0;
               bad_d     = bad_in;
               less_d    = 1'b0;
               equal_d   = 1'b0;
               greater_d = 1'b0;
               invalid_d = 1'b0;
               state_d   = bad_in ? DONE : SCAN;
            end
         end

         SCAN: begin
            mag_d  = dig_res;
            a_nz_d = a_nz_q | (a_dig != '0);
            b_nz_d = b_nz_q | (b_dig != '0);
            if (!dig_eq || idx_q == '0)
               state_d = DONE;
            else
               idx_d = idx_q - 1'b1;
         end

         DONE: begin
            done_d    = 1'b1;
            state_d   = IDLE;
            less_d    = 1'b0;
            equal_d   = 1'b0;
            greater_d = 1'b0;
            invalid_d = 1'b0;
            if (bad_q) begin
               invalid_d = 1'b1;
            end else if (sign_a_q == sign_b_q) begin
               // Two negatives order opposite to their magnitudes.
               equal_d   = (mag_q == EQ);
               less_d    = sign_a_q ? (mag_q == GT) : (mag_q == LT);
               greater_d = sign_a_q ? (mag_q == LT) : (mag_q == GT);
            end else if (mag_q == EQ && !a_nz_q && !b_nz_q) begin
               equal_d = 1'b1;
            end else begin
               greater_d = !sign_a_q;
               less_d    = sign_a_q;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         done_q    <= 1'b0;
         less_q    <= 1'b0;
         equal_q   <= 1'b0;
         greater_q <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         less_q    <= less_d;
         equal_q   <= equal_d;
         greater_q <= greater_d;
         invalid_q <= invalid_d;
      end
   end

   // Operand and scan bookkeeping is always rewritten on acceptance, so no reset.
   always_ff @(posedge clk) begin
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      idx_q    <= idx_d;
      mag_q    <= mag_d;
      a_nz_q   <= a_nz_d;
      b_nz_q   <= b_nz_d;
      bad_q    <= bad_d;
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = done_q;
   assign bus.less    = less_q;
   assign bus.equal   = equal_q;
   assign bus.greater = greater_q;
   assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_signed_bcd_compare_seq.sv
// Bench for signed_bcd_compare_seq: directed cases plus random operands against an
// integer-arithmetic reference of signed BCD comparison and scan latency.
module tb_signed_bcd_compare_seq;

   localparam int D = 3;
   localparam int W = 4 * D;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   signed_bcd_compare_seq_if #(.DIGITS(D)) bus ();

   signed_bcd_compare_seq #(.DIGITS(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: decode magnitudes to integers, compare signed values; k is the count of
   // digits visited MSD-first up to and including the first differing one.
   task automatic model(input logic sa, input logic [W-1:0] a, input logic sb,
                        input logic [W-1:0] b, output logic el, output logic ee,
                        output logic eg, output logic ei, output int k);
      int ma, mb, va, vb, pw;
      logic [3:0] da, db;
      bit found;
      ei = 1'b0; ma = 0; mb = 0; pw = 1;
      for (int i = 0; i < D; i++) begin
         da = a[i*4 +: 4];
         db = b[i*4 +: 4];
         if (da > 4'd9 || db > 4'd9) ei = 1'b1;
         ma += int'(da) * pw;
         mb += int'(db) * pw;
         pw *= 10;
      end
      va = sa ? -ma : ma;
      vb = sb ? -mb : mb;
      el = (va < vb); ee = (va == vb); eg = (va > vb);
      k = D; found = 0;
      for (int i = D - 1; i >= 0; i--) begin
         if (!found && a[i*4 +: 4] != b[i*4 +: 4]) begin
            k = D - i;
            found = 1;
         end
      end
      if (ei) begin
         el = 1'b0; ee = 1'b0; eg = 1'b0; k = 0;
      end
   endtask

   // Entered and left at posedge+#1; a following call drives start in the done cycle.
   task automatic run_cmp(input string tag, input logic sa, input logic [W-1:0] a,
                          input logic sb, input logic [W-1:0] b, input bit restart);
      logic el, ee, eg, ei;
      int k, n;
      bit got;
      model(sa, a, sb, b, el, ee, eg, ei, k);
      bus.start = 1'b1; bus.sign_a = sa; bus.A = a; bus.sign_b = sb; bus.B = b;
      @(posedge clk); #1;
      chk({tag, ".busy_t0"}, 32'(bus.busy), 32'd1);
      chk({tag, ".done_t0"}, 32'(bus.done), 32'd0);
      bus.start  = restart;
      bus.sign_a = ~sa;
      bus.sign_b = ~sb;
      bus.A      = W'($urandom);
      bus.B      = W'($urandom);
      n = 0; got = 0;
      while (!got && n < D + 4) begin
         @(posedge clk); #1;
         n++;
         bus.start = 1'b0;
         if (bus.done) got = 1;
      end
      chk({tag, ".done_seen"}, 32'(got), 32'd1);
      chk({tag, ".latency"}, 32'(n), 32'(k + 1));
      chk({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
      chk({tag, ".less"}, 32'(bus.less), 32'(el));
      chk({tag, ".equal"}, 32'(bus.equal), 32'(ee));
      chk({tag, ".greater"}, 32'(bus.greater), 32'(eg));
      chk({tag, ".invalid"}, 32'(bus.invalid), 32'(ei));
   endtask

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v;
      for (int i = 0; i < D; i++)
         v[i*4 +: 4] = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      return v;
   endfunction

   initial begin
      logic [W-1:0] ra, rb;
      logic sa, sb;
      int j;
      rst = 1'b1;
      bus.start = 1'b0; bus.sign_a = 1'b0; bus.sign_b = 1'b0; bus.A = '0; bus.B = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.done", 32'(bus.done), 32'd0);
      chk("rst.flags", 32'({bus.less, bus.equal, bus.greater, bus.invalid}), 32'd0);

      run_cmp("p123_p129", 1'b0, 12'h123, 1'b0, 12'h129, 0);
      run_cmp("p500_p499", 1'b0, 12'h500, 1'b0, 12'h499, 0);
      run_cmp("n250_n120", 1'b1, 12'h250, 1'b1, 12'h120, 0);
      run_cmp("p000_n000", 1'b0, 12'h000, 1'b1, 12'h000, 0);
      run_cmp("p007_n007", 1'b0, 12'h007, 1'b1, 12'h007, 0);
      run_cmp("n007_p007", 1'b1, 12'h007, 1'b0, 12'h007, 0);
      run_cmp("n042_n042", 1'b1, 12'h042, 1'b1, 12'h042, 0);
      run_cmp("p1A3_p100", 1'b0, 12'h1A3, 1'b0, 12'h100, 0);
      run_cmp("p100_n10F", 1'b0, 12'h100, 1'b1, 12'h10F, 0);
      run_cmp("restart", 1'b0, 12'h999, 1'b0, 12'h998, 1);
      run_cmp("b2b", 1'b1, 12'h999, 1'b0, 12'h000, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("hold.less", 32'(bus.less), 32'd1);
      chk("hold.done", 32'(bus.done), 32'd0);

      // Reset sampled on edge t0+2 of a full-length scan.
      bus.start = 1'b1; bus.sign_a = 1'b0; bus.A = 12'h123; bus.sign_b = 1'b0; bus.B = 12'h129;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst.busy", 32'(bus.busy), 32'd0);
      chk("midrst.done", 32'(bus.done), 32'd0);
      chk("midrst.flags", 32'({bus.less, bus.equal, bus.greater, bus.invalid}), 32'd0);
      j = 0;
      for (int c = 0; c < D + 3; c++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) j++;
      end
      chk("midrst.quiet", 32'(j), 32'd0);

      for (int t = 0; t < 200; t++) begin
         ra = rand_bcd();
         rb = rand_bcd();
         sa = 1'($urandom);
         sb = 1'($urandom);
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: begin
               rb = ra;
               j = $urandom_range(0, D - 1);
               rb[j*4 +: 4] = 4'($urandom_range(0, 9));
            end
            default: ;
         endcase
         if ($urandom_range(0, 9) == 0) begin
            ra = '0;
            rb = '0;
         end
         run_cmp("rand", sa, ra, sb, rb, bit'($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
